// File: rtl/bc_operand_fetch.sv
// Bytecode-operand fetcher: gathers big-endian operand bytes one per cycle, fetching new words as needed.
// Optional sign extension of the assembled operand is enabled by defining BC_OPERAND_SIGN_EXT_EN.
`timescale 1ns/1ps
module bc_operand_fetch #(
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned MAX_PARAMS = 4,
  localparam int unsigned LW = $clog2(WORD_BYTES),
  localparam int unsigned CW = $clog2(MAX_PARAMS + 1),
  localparam int unsigned WW = 8 * WORD_BYTES,
  localparam int unsigned OW = 8 * MAX_PARAMS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] param_count,
  input  logic [LW-1:0] byte_lane,
  input  logic [WW-1:0] cur_word,
  input  logic          sign_ext,
  output logic          fetch,
  input  logic          fetch_ack,
  input  logic [WW-1:0] fetch_data,
  output logic [OW-1:0] operand,
  output logic          done,
  output logic          busy,
  output logic [LW-1:0] next_lane
);

`ifdef BC_OPERAND_SIGN_EXT_EN
  localparam bit SEXT_EN = 1'b1;
`else
  localparam bit SEXT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAKE,
    ST_FETCH,
    ST_DONE
  } state_t;

  state_t        state, state_n;
  logic [WW-1:0] buffer, buffer_n;
  logic [LW-1:0] lane, lane_n;
  logic [CW-1:0] remaining, remaining_n;
  logic [CW-1:0] count_q, count_n;
  logic          sign_q, sign_n;
  logic [OW-1:0] operand_n;
  logic [CW-1:0] clamped;
  logic [7:0]    cur_byte;
  logic          sbit;

  assign clamped  = (param_count > CW'(MAX_PARAMS)) ? CW'(MAX_PARAMS) : param_count;
  assign cur_byte = buffer[{lane, 3'b000} +: 8];

  // Next-state and datapath update
  always_comb begin
    state_n     = state;
    buffer_n    = buffer;
    lane_n      = lane;
    remaining_n = remaining;
    count_n     = count_q;
    sign_n      = sign_q;
    operand_n   = operand;
    sbit        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          count_n     = clamped;
          remaining_n = clamped;
          lane_n      = byte_lane;
          buffer_n    = cur_word;
          sign_n      = sign_ext;
          operand_n   = '0;
          state_n     = (clamped == '0) ? ST_DONE : ST_TAKE;
        end
      end
      ST_TAKE: begin
        operand_n   = (operand << 8) | OW'(cur_byte);
        remaining_n = remaining - CW'(1);
        lane_n      = lane + LW'(1);
        if (remaining_n == '0) begin
          state_n = ST_DONE;
          // Replicate the top operand bit over the unused upper bytes
          if (SEXT_EN && sign_q) begin
            for (int i = 0; i < int'(MAX_PARAMS); i++) begin
              if (count_q == CW'(i + 1)) sbit = operand_n[8*i+7];
            end
            for (int i = 0; i < int'(MAX_PARAMS); i++) begin
              if (CW'(i) >= count_q) operand_n[8*i +: 8] = {8{sbit}};
            end
          end
        end else if (lane == LW'(WORD_BYTES - 1)) begin
          state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_ack) begin
          buffer_n = fetch_data;
          lane_n   = '0;
          state_n  = ST_TAKE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      buffer    <= '0;
      lane      <= '0;
      remaining <= '0;
      count_q   <= '0;
      sign_q    <= 1'b0;
      operand   <= '0;
      fetch     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      next_lane <= '0;
    end else begin
      state     <= state_n;
      buffer    <= buffer_n;
      lane      <= lane_n;
      remaining <= remaining_n;
      count_q   <= count_n;
      sign_q    <= sign_n;
      operand   <= operand_n;
      fetch     <= (state_n == ST_FETCH);
      done      <= (state_n == ST_DONE);
      busy      <= (state_n != ST_IDLE);
      if (state_n == ST_DONE) next_lane <= lane_n;
    end
  end

endmodule

// File: tb/tb_bc_operand_fetch.sv
// Bench for bc_operand_fetch: directed vector table, reset/busy corner sequences and randomized runs
// checked against a byte-stream model of operand collection.
`timescale 1ns/1ps
module tb_bc_operand_fetch;
  localparam int unsigned WB = 2;
  localparam int unsigned MP = 4;
  localparam int unsigned LW = $clog2(WB);
  localparam int unsigned CW = $clog2(MP + 1);
  localparam int unsigned WW = 8 * WB;
  localparam int unsigned OW = 8 * MP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] param_count = '0;
  logic [LW-1:0] byte_lane = '0;
  logic [WW-1:0] cur_word = '0;
  logic          sign_ext = 1'b0;
  logic          fetch;
  logic          fetch_ack = 1'b0;
  logic [WW-1:0] fetch_data = '0;
  logic [OW-1:0] operand;
  logic          done;
  logic          busy;
  logic [LW-1:0] next_lane;

  int n_checks = 0;
  int n_fail = 0;

  bc_operand_fetch #(.WORD_BYTES(WB), .MAX_PARAMS(MP)) dut (
    .clk(clk), .rst(rst), .start(start), .param_count(param_count),
    .byte_lane(byte_lane), .cur_word(cur_word), .sign_ext(sign_ext),
    .fetch(fetch), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .operand(operand), .done(done), .busy(busy), .next_lane(next_lane)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            cnt;
    int            ln;
    logic [WW-1:0] cw;
    bit            sx;
    int            wt;
    logic [WW-1:0] w0;
    logic [WW-1:0] w1;
    bit            poke;
    logic [OW-1:0] op;
    int            nl;
    int            dc;
    int            fc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Launch one operand collection, answer fetches after wt wait cycles, check the result.
  task automatic run_op(input string nm, input int cnt, input int ln, input logic [WW-1:0] cw,
                        input bit sx, input int wt, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                        input bit poke, input logic [OW-1:0] eop, input int enl, input int edc,
                        input int efc);
    int c, dc, fc, w, fidx, busy_bad;
    bit got;
    logic [OW-1:0] op;
    logic [LW-1:0] nl;
    dc = 0; fc = 0; w = 0; fidx = 0; busy_bad = 0; got = 1'b0; op = '0; nl = '0;
    start = 1'b1; param_count = CW'(cnt); byte_lane = LW'(ln); cur_word = cw; sign_ext = sx;
    fetch_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (!got && c < 200) begin
      fetch_ack  = 1'b0;
      fetch_data = WW'($urandom);
      if (done) begin
        got = 1'b1; dc = c; op = operand; nl = next_lane;
      end
      if (!busy) busy_bad++;
      if (fetch) begin
        fc++;
        if (w == wt) begin
          fetch_ack  = 1'b1;
          fetch_data = (fidx == 0) ? w0 : w1;
          fidx++;
          w = 0;
        end else begin
          w++;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        fetch_ack = 1'b1;
      end
      if (poke && c == 1) begin
        start = 1'b1; param_count = CW'(1); byte_lane = '1; cur_word = '1;
      end else begin
        start = 1'b0;
      end
      if (!got) begin
        @(posedge clk); #1;
        c++;
      end
    end
    fetch_ack = 1'b0;
    start = 1'b0;
    check({nm, "_done_seen"}, 64'(got), 64'd1);
    check({nm, "_done_cycle"}, 64'(dc), 64'(edc));
    check({nm, "_operand"}, 64'(op), 64'(eop));
    check({nm, "_next_lane"}, 64'(nl), 64'(enl));
    check({nm, "_fetch_cycles"}, 64'(fc), 64'(efc));
    check({nm, "_busy_drop"}, 64'(busy_bad), 64'd0);
    @(posedge clk); #1;
    check({nm, "_done_pulse"}, 64'(done), 64'd0);
    check({nm, "_idle_busy"}, 64'(busy), 64'd0);
    check({nm, "_operand_hold"}, 64'(operand), 64'(eop));
  endtask

  // Reference: operand bytes form a stream starting at the given lane and continuing through the fetched words.
  function automatic logic [OW-1:0] model_op(input int cnt, input int ln, input logic [WW-1:0] cw,
                                             input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                                             input bit sx);
    logic [7:0] q[$];
    logic [63:0] acc;
    int n;
    for (int k = ln; k < int'(WB); k++) q.push_back(cw[8*k +: 8]);
    for (int k = 0; k < int'(WB); k++) q.push_back(w0[8*k +: 8]);
    for (int k = 0; k < int'(WB); k++) q.push_back(w1[8*k +: 8]);
    n = (cnt > int'(MP)) ? int'(MP) : cnt;
    acc = '0;
    for (int i = 0; i < n; i++) acc = (acc << 8) | 64'(q[i]);
`ifdef BC_OPERAND_SIGN_EXT_EN
    if (sx && n > 0 && acc[8*n-1]) acc = acc | ~((64'd1 << (8*n)) - 64'd1);
`else
    if (sx) acc = acc;
`endif
    return OW'(acc);
  endfunction

  initial begin
    int cnt, ln, wt, n, nf;
    logic [WW-1:0] cw, w0, w1;
    bit sx;

    vecs[0] = '{"two_lane0", 2, 0, 16'hBBAA, 0, 0, 16'h0000, 16'h0000, 0, 32'h0000AABB, 0, 3, 0};
    vecs[1] = '{"two_lane1_wait", 2, 1, 16'h1234, 0, 2, 16'h5678, 16'h0000, 0, 32'h00001278, 1, 6, 3};
    vecs[2] = '{"count_zero", 0, 1, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0, 32'h00000000, 1, 1, 0};
    vecs[3] = '{"count_clamp", 7, 0, 16'hBBAA, 0, 0, 16'hDDCC, 16'h0000, 0, 32'hAABBCCDD, 0, 6, 1};
`ifdef BC_OPERAND_SIGN_EXT_EN
    vecs[4] = '{"sign_ext", 1, 0, 16'h0080, 1, 0, 16'h0000, 16'h0000, 0, 32'hFFFFFF80, 1, 2, 0};
`else
    vecs[4] = '{"sign_ext", 1, 0, 16'h0080, 1, 0, 16'h0000, 16'h0000, 0, 32'h00000080, 1, 2, 0};
`endif
    vecs[5] = '{"four_two_fetch", 4, 1, 16'h11EE, 0, 0, 16'h3322, 16'h5544, 0, 32'h11223344, 1, 7, 2};
    vecs[6] = '{"start_busy", 2, 0, 16'hBBAA, 0, 1, 16'h0000, 16'h0000, 1, 32'h0000AABB, 0, 3, 0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_fetch", 64'(fetch), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_operand", 64'(operand), 64'd0);
    check("rst_next_lane", 64'(next_lane), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].name, vecs[i].cnt, vecs[i].ln, vecs[i].cw, vecs[i].sx, vecs[i].wt,
             vecs[i].w0, vecs[i].w1, vecs[i].poke, vecs[i].op, vecs[i].nl, vecs[i].dc, vecs[i].fc);

    // Reset while a fetch is outstanding, then an ordinary collection right after
    start = 1'b1; param_count = CW'(2); byte_lane = LW'(1); cur_word = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10 && !fetch; k++) begin
      @(posedge clk); #1;
    end
    check("fetch_before_rst", 64'(fetch), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_fetch", 64'(fetch), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_operand", 64'(operand), 64'd0);
    check("midrst_next_lane", 64'(next_lane), 64'd0);
    run_op("after_rst", 2, 1, 16'h1234, 0, 0, 16'h5678, 16'h0000, 0, 32'h00001278, 1, 4, 1);

    for (int r = 0; r < 30; r++) begin
      cnt = $urandom_range(0, 7);
      ln  = $urandom_range(0, WB - 1);
      wt  = $urandom_range(0, 3);
      sx  = 1'($urandom);
      cw  = WW'($urandom);
      w0  = WW'($urandom);
      w1  = WW'($urandom);
      n   = (cnt > int'(MP)) ? int'(MP) : cnt;
      nf  = (n == 0) ? 0 : (ln + n + int'(WB) - 1) / int'(WB) - 1;
      run_op($sformatf("rand%0d", r), cnt, ln, cw, sx, wt, w0, w1, 0,
             model_op(cnt, ln, cw, w0, w1, sx), (ln + n) % int'(WB),
             (n == 0) ? 1 : 1 + n + nf * (wt + 1), nf * (wt + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bc_operand_fetch.md
# bc_operand_fetch

Parametrised bytecode-operand fetcher for the JVM front end: given the currently buffered instruction word, the byte lane where an instruction's parameters start and the parameter count, it collects the operand bytes one per cycle and requests further instruction words when a word runs out. It assembles a big-endian (JVM-order) operand and reports the lane following the last byte. It replaces the fixed 2-byte/even-odd fetch decision with arbitrary word width, operand length, fetch handshake and optional sign extension.

## Interface
- WORD_BYTES, 2, bytes per instruction-memory word; power of two, 2..8
- MAX_PARAMS, 4, maximum operand bytes per instruction, 1..8
- Derived: LW = $clog2(WORD_BYTES); CW = $clog2(MAX_PARAMS+1)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin collection; sampled only in IDLE
- param_count  in  CW  operand bytes; values > MAX_PARAMS are clamped to MAX_PARAMS
- byte_lane  in  LW  lane of first operand byte within cur_word
- cur_word  in  8*WORD_BYTES  buffered word; lane k = bits [8k+7:8k]
- sign_ext  in  1  request sign extension (used only with macro)
- fetch  out  1  next-word request, held until fetch_ack
- fetch_ack  in  1  fetch_data valid this cycle
- fetch_data  in  8*WORD_BYTES  fetched word, same lane layout
- operand  out  8*MAX_PARAMS  assembled operand, right-justified
- done  out  1  one-cycle pulse, operand/next_lane valid
- busy  out  1  high in every state except IDLE
- next_lane  out  LW  lane after last consumed byte

## Operation
- States: IDLE, TAKE, FETCH, DONE.
- IDLE: on start, latch clamped count, byte_lane, cur_word, sign_ext; clear operand. count==0 -> DONE, else -> TAKE.
- TAKE: operand <= (operand << 8) | buffer[lane]; remaining--; lane <= lane+1 mod WORD_BYTES. remaining reaches 0 -> DONE; else if consumed lane was WORD_BYTES-1 -> FETCH; else stay.
- FETCH: fetch=1; on fetch_ack load buffer from fetch_data, lane <= 0, -> TAKE.
- DONE: done=1, next_lane = (byte_lane + count) mod WORD_BYTES; -> IDLE. operand holds until next accepted start.
- Last byte at lane WORD_BYTES-1 does not trigger fetch; next_lane = 0 (caller advances the word).
- Ignored: start when busy, fetch_ack outside FETCH.

## Timing
- Reset values: fetch 0, done 0, busy 0, operand 0, next_lane 0, state IDLE.
- start sampled at edge 0; TAKE occupies cycles 1..n; with no fetch, done in cycle n+1.
- Each fetch adds one FETCH cycle plus ack-wait cycles; ack in the first FETCH cycle resumes TAKE next cycle.
- count==0: done in cycle 1, operand 0, next_lane = byte_lane.
- rst at any state (incl. FETCH with fetch high): all outputs at reset values after that edge; start accepted the cycle after rst deasserts.

## Configuration
- BC_OPERAND_SIGN_EXT_EN defined: if latched sign_ext=1 and count>0, operand bits above 8*count-1 replicate bit 8*count-1 at DONE; sign_ext=0 gives zero extension.
- Undefined: operand always zero-extended; sign_ext port present but ignored.

## Test plan
(WORD_BYTES=2, MAX_PARAMS=4)
- count=2, lane=0, cur_word=16'hBBAA -> operand 32'h0000AABB, done cycle 3, fetch never high, next_lane 0.
- count=2, lane=1, cur_word=16'h1234; ack in cycle 4 with 16'h5678 -> fetch high cycles 2-4, done cycle 6, operand 32'h00001278, next_lane 1.
- count=0 -> done cycle 1, operand 0; count=7 -> clamped to 4 bytes; start while busy -> no effect.
- count=1, lane=0, cur_word=16'h0080, sign_ext=1 -> 32'hFFFFFF80 with BC_OPERAND_SIGN_EXT_EN, 32'h00000080 without.
- count=4, lane=1, immediate acks with 16'h3322, 16'h5544 (cur_word 16'h11xx) -> two fetches, operand 32'h11223344, next_lane 1.
- rst asserted during FETCH -> fetch/busy 0 next cycle; subsequent start completes normally.
